// File: rtl/trigger_gen.sv
// Programmable trigger-pulse generator.
// On start, emits N single-cycle trigger pulses P clocks apart, then pulses done.
module trigger_gen #(
    parameter int PERIOD_W = 16,
    parameter int COUNT_W  = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic [PERIOD_W-1:0] period,
    input  logic [COUNT_W-1:0]  burst,
    output logic                trigger,
    output logic                busy,
    output logic                done,
    output logic [COUNT_W-1:0]  sent
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state;
    logic [PERIOD_W-1:0] per_q;
    logic [PERIOD_W-1:0] cnt;
    logic [COUNT_W-1:0]  num_q;
    logic [PERIOD_W-1:0] per_eff;
    logic                go;

    // A zero period would never re-fire; it is treated as back-to-back pulses.
    assign per_eff = (period == '0) ? PERIOD_W'(1) : period;
    assign go      = start && !abort;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state   <= IDLE;
            per_q   <= '0;
            num_q   <= '0;
            cnt     <= '0;
            trigger <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sent    <= '0;
        end else begin
            trigger <= 1'b0;
            done    <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (go) begin
                        per_q <= per_eff;
                        num_q <= burst;
                        if (burst == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            sent  <= '0;
                            cnt   <= '0;
                        end else begin
                            state   <= RUN;
                            trigger <= 1'b1;
                            busy    <= 1'b1;
                            sent    <= COUNT_W'(1);
                            cnt     <= per_eff - PERIOD_W'(1);
                        end
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                RUN: begin
                    // Abort outranks completion: a final pulse may go out, done never does.
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (sent == num_q) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else if (cnt == '0) begin
                        trigger <= 1'b1;
                        sent    <= sent + COUNT_W'(1);
                        cnt     <= per_q - PERIOD_W'(1);
                    end else begin
                        cnt <= cnt - PERIOD_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trigger_gen.sv
// Bench for trigger_gen: arithmetic burst-schedule model checked every cycle,
// plus hand-computed waveform vectors for the directed scenarios.
module tb_trigger_gen;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] period = '0;
    logic [7:0]  burst = '0;
    logic        trigger;
    logic        busy;
    logic        done;
    logic [7:0]  sent;

    trigger_gen #(.PERIOD_W(16), .COUNT_W(8)) dut (
        .clock(clock), .reset(reset), .start(start), .abort(abort),
        .period(period), .burst(burst), .trigger(trigger), .busy(busy),
        .done(done), .sent(sent)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    bit chk_en = 0;

    // Model: a burst accepted at the edge ending cycle c has pulse i in cycle s+(i-1)*P, s=c+1.
    bit act = 0;
    int s = 0;
    int P = 1;
    int N = 0;
    int hold = 0;

    function automatic bit m_busy(int t);
        return act && N > 0 && t >= s && t <= s + (N - 1) * P;
    endfunction

    function automatic bit m_trig(int t);
        return m_busy(t) && ((t - s) % P == 0);
    endfunction

    function automatic bit m_done(int t);
        if (!act) return 1'b0;
        if (N == 0) return t == s;
        return t == s + (N - 1) * P + 1;
    endfunction

    function automatic int m_sent(int t);
        int k;
        if (!act) return hold;
        if (t < s || N == 0) return 0;
        k = (t - s) / P + 1;
        return (k < N) ? k : N;
    endfunction

    always @(posedge clock) begin : model
        int c;
        c = cyc;
        if (!reset) begin
            act    = 0;
            hold   = 0;
            chk_en = 1;
        end else if (abort) begin
            if (m_busy(c)) begin
                hold = m_sent(c);
                act  = 0;
            end
        end else if (start && !m_busy(c)) begin
            act = 1;
            s   = c + 1;
            P   = (period == 0) ? 1 : int'(period);
            N   = int'(burst);
        end
        cyc = cyc + 1;
    end

    task automatic check(input string nm, input logic [31:0] got, input int exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", nm, cyc, got, exp);
        end
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            check("trigger", {31'd0, trigger}, int'(m_trig(cyc)));
            check("busy", {31'd0, busy}, int'(m_busy(cyc)));
            check("done", {31'd0, done}, int'(m_done(cyc)));
            check("sent", {24'd0, sent}, m_sent(cyc));
        end
    end

    // Capture 16 cycles after a start; optionally abort or re-poke start at an offset.
    task automatic capture(input int p, input int b, input int abort_at,
                           input int poke_at, input int pp, input int pb,
                           output logic [15:0] tv, output logic [15:0] bv,
                           output logic [15:0] dv, output int last_sent,
                           output int ntrig);
        @(negedge clock);
        start  = 1'b1;
        period = 16'(p);
        burst  = 8'(b);
        @(negedge clock);
        start = 1'b0;
        tv = '0;
        bv = '0;
        dv = '0;
        ntrig = 0;
        for (int i = 0; i < 16; i++) begin
            tv[i] = trigger;
            bv[i] = busy;
            dv[i] = done;
            ntrig += int'(trigger);
            abort = (i == abort_at);
            start = (i == poke_at);
            if (i == poke_at) begin
                period = 16'(pp);
                burst  = 8'(pb);
            end
            @(negedge clock);
        end
        abort = 1'b0;
        start = 1'b0;
        last_sent = int'(sent);
    endtask

    logic [15:0] tv, bv, dv;
    int ls, nt;

    initial begin
        start  = 1'b1;
        period = 16'd4;
        burst  = 8'd3;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("rst_trigger", {31'd0, trigger}, 0);
            check("rst_busy", {31'd0, busy}, 0);
            check("rst_sent", {24'd0, sent}, 0);
        end
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clock);
        check("post_rst_trigger", {31'd0, trigger}, 0);

        capture(4, 3, -1, -1, 0, 0, tv, bv, dv, ls, nt);
        check("p4b3_trig", {16'd0, tv}, 32'h0111);
        check("p4b3_busy", {16'd0, bv}, 32'h01FF);
        check("p4b3_done", {16'd0, dv}, 32'h0200);
        check("p4b3_sent", ls, 3);

        capture(1, 5, -1, -1, 0, 0, tv, bv, dv, ls, nt);
        check("p1b5_trig", {16'd0, tv}, 32'h001F);
        check("p1b5_done", {16'd0, dv}, 32'h0020);
        check("p1b5_count", nt, 5);

        capture(10, 0, -1, -1, 0, 0, tv, bv, dv, ls, nt);
        check("b0_trig", {16'd0, tv}, 0);
        check("b0_busy", {16'd0, bv}, 0);
        check("b0_done", {16'd0, dv}, 32'h0001);

        capture(3, 10, 10, -1, 0, 0, tv, bv, dv, ls, nt);
        check("abort_trig", {16'd0, tv}, 32'h0249);
        check("abort_busy", {16'd0, bv}, 32'h07FF);
        check("abort_done", {16'd0, dv}, 0);
        check("abort_sent", ls, 4);

        capture(3, 4, -1, -1, 0, 0, tv, bv, dv, ls, nt);
        check("rerun_trig", {16'd0, tv}, 32'h0249);
        check("rerun_done", {16'd0, dv}, 32'h0400);
        check("rerun_sent", ls, 4);

        capture(4, 3, -1, 2, 7, 9, tv, bv, dv, ls, nt);
        check("midrun_trig", {16'd0, tv}, 32'h0111);
        check("midrun_done", {16'd0, dv}, 32'h0200);
        check("midrun_sent", ls, 3);

        capture(2, 2, -1, 3, 1, 1, tv, bv, dv, ls, nt);
        check("restart_trig", {16'd0, tv}, 32'h0015);
        check("restart_busy", {16'd0, bv}, 32'h0017);
        check("restart_done", {16'd0, dv}, 32'h0028);

        capture(0, 3, -1, -1, 0, 0, tv, bv, dv, ls, nt);
        check("p0_trig", {16'd0, tv}, 32'h0007);
        check("p0_done", {16'd0, dv}, 32'h0008);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clock);
            start  = ($urandom % 6 == 0);
            abort  = ($urandom % 25 == 0);
            period = 16'($urandom % 6);
            burst  = ($urandom % 8 == 0) ? 8'd0 : 8'($urandom % 7 + 1);
            reset  = ($urandom % 300 != 0);
        end
        @(negedge clock);
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        repeat (5) @(negedge clock);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
